segment_scan_decoder: RTL
=========================

# segment_scan_decoder

Recovers BCD digit values from a time-multiplexed seven-segment display drive bus: the segment lines and one-hot digit enables that feed a display. It samples the bus, waits for each digit's drive to stay stable, converts the glyph back to a 4-bit value, and flags patterns that are not legal digits. It sits on the observation side of the display path and is used to self-check display drivers and to read panels driven by external logic.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions, 1–8.
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a capture, 2–15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `seg` input 7: segment lines, active-high; bit 6 = a, 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g.
- `anode` input DIGITS: digit enables, active-high, one-hot when valid.
- `digits` output 4*DIGITS: decoded values; slice [4i+3:4i] belongs to digit i.
- `digit_valid` output DIGITS: bit i is set when the last capture of digit i was a legal glyph.
- `err` output 1: one-cycle pulse when an illegal glyph is captured.
- `err_digit` output 3: index of the digit that caused the last `err`; held until the next error.
- `frame_valid` output 1: one-cycle pulse when every digit has been captured since the last frame and all captures were legal.

## Operation
- **Input register.** `seg` and `anode` are registered every cycle into `seg_q` and `anode_q`. All decisions use the registered values. A stability counter compares the current registered value against the previous one.
- **FSM states.**
  - IDLE: `anode_q` is not one-hot (zero or multiple bits set). The counter is cleared.
  - TRACK: one-hot, counting identical samples. The counter is 1 on entry, increments while `{anode_q, seg_q}` is unchanged, and restarts at 1 on any change while still one-hot.
  - HOLD: the current dwell has already been captured.
- **Transitions.**
  - Any state goes to IDLE when `anode_q` is not one-hot.
  - IDLE goes to TRACK when `anode_q` is one-hot.
  - TRACK goes to HOLD when the counter reaches STABLE_CYCLES; this is the capture.
  - HOLD goes to TRACK when `seg_q` or `anode_q` changes and is still one-hot, so a re-capture is allowed.
  - HOLD stays in HOLD while the sample is unchanged. Only one capture happens per stable dwell.
- **Glyph table (abcdefg).**
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Every other pattern is illegal, including all-off.
- **Capture of digit i.**
  - Legal glyph: slice i is updated to the value and `digit_valid[i]` is set.
  - Illegal glyph: slice i keeps its old value, `digit_valid[i]` is cleared, `err` pulses, and `err_digit` is set to i.
- **Frame tracking.**
  - A `seen` mask sets bit i on every capture, legal or illegal.
  - In the cycle after `seen` becomes all-ones, `frame_valid` pulses if `digit_valid` is all-ones; otherwise there is no pulse.
  - `seen` clears in that same cycle either way.
- **Counter.** Saturates at STABLE_CYCLES and does not wrap.
- **Reset.**
  - Asynchronous reset at any time, including mid-dwell, forces IDLE.
  - Counter, `seen`, `seg_q` and `anode_q` go to 0.
  - Outputs after reset: `digits` = 0, `digit_valid` = 0, `err` = 0, `err_digit` = 0, `frame_valid` = 0.

## Timing
- Input applied before edge 0 and held: `seg_q` is valid from edge 0.
- The capture condition is true after edge STABLE_CYCLES−1. `digits`, `digit_valid` and `err` update at edge STABLE_CYCLES. With the default of 3, that is the 4th edge after the input appears.
- `frame_valid` asserts one edge after the capture that completes `seen`, and lasts exactly one cycle.
- A glitch shorter than STABLE_CYCLES samples never captures. It only restarts the counter.
- Anode switching directly from digit i to digit j (both one-hot) restarts the counter at 1 for j, with no pass through IDLE.
- Same-cycle events:
  - A capture and the completion of `seen` in the same cycle count that capture toward the frame.
  - An `err` and a `frame` evaluation in the same cycle are judged with the updated `digit_valid`.

## Configuration
- `SEG_ALT_GLYPH_EN` defined: these alternate glyphs are also legal and decode normally.
  - 6 without segment a: 0011111
  - 7 with segment f: 1110010
  - 9 without segment d: 1110011
- `SEG_ALT_GLYPH_EN` undefined: only the base table is legal, and the three patterns above raise `err`.

## Test plan
- **Reset:** assert `reset_n`=0 mid-TRACK → all outputs 0 immediately; after release, no capture until STABLE_CYCLES fresh stable samples.
- **Capture latency:** DIGITS=4, STABLE_CYCLES=3, `anode`=0001, `seg`=1111001 held → `digits[3:0]`=3 and `digit_valid[0]`=1 at the 4th edge; no `err`.
- **Full frame:** scan digits 0..3 with glyphs 1,2,5,9, 6 cycles each → `digits`=16'h9521; single `frame_valid` pulse one edge after the digit-3 capture.
- **Illegal glyph:** `anode`=0100, `seg`=0000001 → `err` pulse, `err_digit`=2, `digit_valid[2]`=0, `digits[11:8]` unchanged; that frame produces no `frame_valid`.
- **Glitch and blanking:** 2-cycle glyph, then `anode`=0000, then `anode`=0011 → no capture, no `err`, state IDLE.
- **Alternate glyph:** `seg`=0011111 stable → value 6 with `SEG_ALT_GLYPH_EN` defined; `err` without it.

Source files
------------

// File: rtl/segment_scan_decoder.sv
// segment_scan_decoder
// Watches a multiplexed seven-segment drive bus (segments plus one-hot digit
// enables). Each digit dwell is captured once it has held steady for
// STABLE_CYCLES samples. The glyph is decoded back to a BCD value and illegal
// patterns are flagged. A frame pulse marks a complete, fully legal scan of
// every digit position.
// Optional feature: define SEG_ALT_GLYPH_EN to also accept the alternate
// 6 / 7 / 9 glyph shapes.
module segment_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     anode,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  err,
    output logic [2:0]            err_digit,
    output logic                  frame_valid
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [6:0]          seg_q;
    logic [6:0]          seg_p;
    logic [DIGITS-1:0]   anode_q;
    logic [DIGITS-1:0]   anode_p;

    logic [3:0]          count;
    logic [3:0]          count_next;

    logic                one_hot;
    logic                changed;
    logic                capture;
    logic                glyph_ok;
    logic [3:0]          glyph_val;
    logic [2:0]          index;

    logic [DIGITS-1:0]   seen;
    logic [DIGITS-1:0]   seen_next;
    logic                seen_full;
    logic [DIGITS-1:0]   valid_next;
    logic [4*DIGITS-1:0] digits_next;

    // Register the raw bus, and keep the previous registered sample for
    // stability comparison.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q   <= '0;
            anode_q <= '0;
            seg_p   <= '0;
            anode_p <= '0;
        end else begin
            seg_q   <= seg;
            anode_q <= anode;
            seg_p   <= seg_q;
            anode_p <= anode_q;
        end
    end

    // Classify the registered sample: one-hot enable, and whether it differs
    // from the sample before it.
    always_comb begin
        one_hot = (anode_q != '0) &&
                  ((anode_q & (anode_q - DIGITS'(1))) == '0);
        changed = (anode_q != anode_p) || (seg_q != seg_p);
    end

    // Position of the active digit enable, used for the error index.
    always_comb begin
        index = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (anode_q[i]) begin
                index = 3'(i);
            end
        end
    end

    // Map the registered segment pattern back to a BCD value.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'd0;
        case (seg_q)
            7'b1111110: glyph_val = 4'd0;
            7'b0110000: glyph_val = 4'd1;
            7'b1101101: glyph_val = 4'd2;
            7'b1111001: glyph_val = 4'd3;
            7'b0110011: glyph_val = 4'd4;
            7'b1011011: glyph_val = 4'd5;
            7'b1011111: glyph_val = 4'd6;
            7'b1110000: glyph_val = 4'd7;
            7'b1111111: glyph_val = 4'd8;
            7'b1111011: glyph_val = 4'd9;
`ifdef SEG_ALT_GLYPH_EN
            7'b0011111: glyph_val = 4'd6;
            7'b1110010: glyph_val = 4'd7;
            7'b1110011: glyph_val = 4'd9;
`endif
            default:    glyph_ok  = 1'b0;
        endcase
    end

    // Dwell tracking: count identical one-hot samples and capture exactly once
    // per stable dwell; the counter saturates instead of wrapping.
    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        if (!one_hot) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = TRACK;
                    count_next = 4'd1;
                end
                TRACK: begin
                    if (changed) begin
                        count_next = 4'd1;
                    end else if (count >= STABLE - 4'd1) begin
                        count_next = STABLE;
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        count_next = count + 4'd1;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_next = TRACK;
                        count_next = 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // State and stability counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next values of the decoded digits and their legality flags on capture;
    // an illegal glyph keeps the old value but drops the valid flag.
    always_comb begin
        digits_next = digits;
        valid_next  = digit_valid;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && anode_q[i]) begin
                if (glyph_ok) begin
                    digits_next[4*i +: 4] = glyph_val;
                    valid_next[i]         = 1'b1;
                end else begin
                    valid_next[i]         = 1'b0;
                end
            end
        end
    end

    // Frame bookkeeping: a full seen mask is evaluated and cleared one cycle
    // after it fills, while still accepting a capture landing in that cycle.
    always_comb begin
        seen_full = &seen;
        seen_next = seen_full ? '0 : seen;
        if (capture) begin
            seen_next = seen_next | anode_q;
        end
    end

    // Output registers: decoded values, error pulse and index, frame pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits      <= '0;
            digit_valid <= '0;
            err         <= 1'b0;
            err_digit   <= '0;
            frame_valid <= 1'b0;
            seen        <= '0;
        end else begin
            digits      <= digits_next;
            digit_valid <= valid_next;
            err         <= capture && !glyph_ok;
            if (capture && !glyph_ok) begin
                err_digit <= index;
            end
            frame_valid <= seen_full && (&valid_next);
            seen        <= seen_next;
        end
    end

endmodule
